// File: rtl/dl_lshift_arb_pkg.sv
// Shared constants and types for the dl_lshift_arb shared shifter.
// Optional stall counter is enabled by DL_LSHIFT_ARB_STALL_CNT_EN.
package dl_lshift_arb_pkg;

  localparam int DEF_NUM_BITS    = 32;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_ID_BITS     = $clog2(DEF_NUM_REQ);
  localparam int STALL_CNT_BITS  = 32;

  // Response record at the default configuration.
  typedef struct packed {
    logic [DEF_ID_BITS-1:0]  id;
    logic [DEF_NUM_BITS-1:0] data;
  } rsp_t;

endpackage

// File: rtl/dl_lshift.sv
// Zero-fill left shifter; amounts at or beyond NUM_BITS produce zero.
module dl_lshift #(
  parameter int NUM_BITS = 32,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS)
) (
  input  logic [NUM_BITS-1:0]       in,
  input  logic [NUM_SHIFT_BITS-1:0] shamt,
  output logic [NUM_BITS-1:0]       out
);

  generate
    if (NUM_BITS == (1 << NUM_SHIFT_BITS)) begin : g_pow2
      assign out = in << shamt;
    end else begin : g_npow2
      // Non power-of-2 widths can encode amounts past the operand width.
      assign out = (shamt >= NUM_SHIFT_BITS'(NUM_BITS)) ? '0 : (in << shamt);
    end
  endgenerate

endmodule

// File: rtl/dl_rr_arbiter.sv
// Round-robin arbiter: scans req from rr_ptr upward and advances past the winner on update.
module dl_rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_BITS = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               upd,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_BITS-1:0] idx
);

  logic [ID_BITS-1:0] rr_ptr_q, rr_ptr_d;
  logic               found;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!found && req[(int'(rr_ptr_q) + off) % NUM_REQ]) begin
        idx   = ID_BITS'((int'(rr_ptr_q) + off) % NUM_REQ);
        found = 1'b1;
      end
    end
    grant = '0;
    if (en && found) grant[idx] = 1'b1;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (upd) rr_ptr_d = ID_BITS'((int'(idx) + 1) % NUM_REQ);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/dl_lshift_arb.sv
// One left shifter shared by NUM_REQ requesters behind a round-robin arbiter and a one-entry result stage.
// Define DL_LSHIFT_ARB_STALL_CNT_EN to add the saturating stall_cnt output.
module dl_lshift_arb
  import dl_lshift_arb_pkg::*;
#(
  parameter int NUM_BITS = DEF_NUM_BITS,
  parameter int NUM_REQ  = DEF_NUM_REQ,
  localparam int NUM_SHIFT_BITS = $clog2(NUM_BITS),
  localparam int ID_BITS        = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic [NUM_REQ*NUM_BITS-1:0]       req_data,
  input  logic [NUM_REQ*NUM_SHIFT_BITS-1:0] req_shamt,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [NUM_BITS-1:0]               rsp_data,
  output logic [ID_BITS-1:0]                rsp_id
`ifdef DL_LSHIFT_ARB_STALL_CNT_EN
  ,
  output logic [STALL_CNT_BITS-1:0]         stall_cnt
`endif
);

  logic                      rsp_valid_q, rsp_valid_d;
  logic [NUM_BITS-1:0]       rsp_data_q, rsp_data_d;
  logic [ID_BITS-1:0]        rsp_id_q, rsp_id_d;
  logic                      can_accept;
  logic                      transfer;
  logic [NUM_REQ-1:0]        grant;
  logic [ID_BITS-1:0]        win_idx;
  logic [NUM_BITS-1:0]       win_data;
  logic [NUM_SHIFT_BITS-1:0] win_shamt;
  logic [NUM_BITS-1:0]       shifted;

  assign can_accept = !rsp_valid_q || rsp_ready;

  dl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (can_accept),
    .upd   (transfer),
    .grant (grant),
    .idx   (win_idx)
  );

  assign req_ready = grant;
  assign transfer  = |(req_valid & req_ready);

  assign win_data  = req_data[int'(win_idx)*NUM_BITS +: NUM_BITS];
  assign win_shamt = req_shamt[int'(win_idx)*NUM_SHIFT_BITS +: NUM_SHIFT_BITS];

  dl_lshift #(.NUM_BITS(NUM_BITS)) u_shift (
    .in    (win_data),
    .shamt (win_shamt),
    .out   (shifted)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    if (transfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = shifted;
      rsp_id_d    = win_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef DL_LSHIFT_ARB_STALL_CNT_EN
  logic [STALL_CNT_BITS-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (rsp_valid_q && !rsp_ready && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dl_lshift_arb.sv
// Self-checking bench for dl_lshift_arb: directed vector table, corner sequences, randomized traffic vs a reference model.
module tb_dl_lshift_arb;
  import dl_lshift_arb_pkg::*;

  localparam int NB = 32;
  localparam int NR = 4;
  localparam int SB = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req_valid = '0;
  logic [NR-1:0]   req_ready;
  logic [NR*NB-1:0] req_data = '0;
  logic [NR*SB-1:0] req_shamt = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [NB-1:0]   rsp_data;
  logic [1:0]      rsp_id;
`ifdef DL_LSHIFT_ARB_STALL_CNT_EN
  logic [31:0]     stall_cnt;
`endif

  dl_lshift_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .req_shamt (req_shamt),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
`ifdef DL_LSHIFT_ARB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: held result, next-priority requester, stall count.
  bit          m_valid;
  rsp_t        m_rsp;
  int          m_ptr;
  logic [31:0] m_stall;
  int          last_xfer;
  int          waitc [NR];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] shl(input logic [31:0] d, input logic [4:0] s);
    logic [63:0] wide;
    wide = {32'h0, d} * (64'h1 << s);
    return wide[31:0];
  endfunction

  task automatic set_req(input int i, input logic [31:0] d, input logic [4:0] s);
    req_data[i*NB +: NB]  = d;
    req_shamt[i*SB +: SB] = s;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_rsp   = '0;
    m_ptr   = 0;
    m_stall = '0;
    for (int i = 0; i < NR; i++) waitc[i] = 0;
  endtask

  // One clock: check handshake before the edge, advance the model, check the result stage after it.
  task automatic tick();
    bit can;
    int w;
    logic [NR-1:0] er;
    #1;
    can = !m_valid || rsp_ready;
    w = -1;
    for (int o = 0; o < NR; o++)
      if (w < 0 && req_valid[(m_ptr + o) % NR]) w = (m_ptr + o) % NR;
    er = '0;
    if (can && w >= 0) er[w] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    @(posedge clk);
    if (m_valid && !rsp_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
    if (er != '0) begin
      for (int i = 0; i < NR; i++) begin
        if (i == w || !req_valid[i]) waitc[i] = 0;
        else begin
          waitc[i]++;
          chk("fairness", 64'(waitc[i] < NR), 64'd1);
        end
      end
      m_valid    = 1'b1;
      m_rsp.data = shl(req_data[w*NB +: NB], req_shamt[w*SB +: SB]);
      m_rsp.id   = 2'(w);
      m_ptr      = (w + 1) % NR;
      last_xfer  = w;
    end else begin
      if (rsp_ready) m_valid = 1'b0;
      last_xfer = -1;
    end
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_data", 64'(rsp_data), 64'(m_rsp.data));
    chk("rsp_id", 64'(rsp_id), 64'(m_rsp.id));
`ifdef DL_LSHIFT_ARB_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  typedef struct {
    int          req;
    logic [31:0] data;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{0, 32'h0000_0001, 5'd4,  32'h0000_0010};
    vecs[1] = '{1, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
    vecs[2] = '{2, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5};
    vecs[3] = '{0, 32'h1234_5678, 5'd8,  32'h3456_7800};
    vecs[4] = '{1, 32'h8000_0001, 5'd1,  32'h0000_0002};
    vecs[5] = '{3, 32'hDEAD_BEEF, 5'd16, 32'hBEEF_0000};

    model_reset();
    last_xfer = -1;
    repeat (2) @(negedge clk);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, one requester at a time.
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_valid = '0;
      req_valid[vecs[k].req] = 1'b1;
      set_req(vecs[k].req, vecs[k].data, vecs[k].sh);
      #1;
      chk("vec_ready", 64'(req_ready), 64'(1 << vecs[k].req));
      tick();
      chk("vec_valid", 64'(rsp_valid), 64'd1);
      chk("vec_data", 64'(rsp_data), 64'(vecs[k].exp));
      chk("vec_id", 64'(rsp_id), 64'(vecs[k].req));
    end
    req_valid = '0;

    // All requesters continuously valid: grants rotate 0,1,2,3.
    for (int i = 0; i < NR; i++) set_req(i, $urandom, 5'($urandom_range(0, 31)));
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_seq_id", 64'(rsp_id), 64'(k % NR));
    end

    // Backpressure with req1 and req2 pending.
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_ready", 64'(req_ready), 64'd0);
      tick();
      chk("stall_id", 64'(rsp_id), 64'd3);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release_ready", 64'(req_ready), 64'b0010);
    tick();
    chk("release_id", 64'(rsp_id), 64'd1);
    req_valid = 4'b0100;
    tick();
    chk("release2_id", 64'(rsp_id), 64'd2);
    req_valid = '0;
    tick();

    // Pointer wrap: req3 alone, then req0 and req3 together.
    req_valid = 4'b1000;
    tick();
    req_valid = 4'b1001;
    #1;
    chk("wrap_ready0", 64'(req_ready), 64'b0001);
    tick();
    chk("wrap_id0", 64'(rsp_id), 64'd0);
    req_valid = 4'b1000;
    #1;
    chk("wrap_ready3", 64'(req_ready), 64'b1000);
    tick();
    chk("wrap_id3", 64'(rsp_id), 64'd3);

    // Reset while a result is held under stall.
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_data", 64'(rsp_data), 64'd0);
`ifdef DL_LSHIFT_ARB_STALL_CNT_EN
    chk("async_rst_stall", 64'(stall_cnt), 64'd0);
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    #1;
    chk("post_rst_ready", 64'(req_ready), 64'b0001);
    tick();
    chk("post_rst_id", 64'(rsp_id), 64'd0);
    req_valid = '0;

    // Randomized traffic; requesters hold valid and payload until accepted.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (last_xfer == i) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom_range(0, 99) < 40)) begin
          req_valid[i] = 1'b1;
          set_req(i, $urandom, 5'($urandom_range(0, 31)));
        end
      end
      rsp_ready = ($urandom_range(0, 99) < 65);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
